led_fade_engine: RTL

//  Per-channel brightness fader between the I2C register file and the PWM channels.

---
 rtl/led_fade_engine.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/led_fade_engine.sv
// led_fade_engine: per-channel brightness fader feeding the PWM channels.
// Holds one target per channel and walks each live level toward its target,
// one channel per clock, on every prescaler tick.
//   clk, rst_n         system clock, asynchronous active-low reset
//   tgt_wen/ch/val     target write port (writes to ch >= NCH are dropped)
//   rate_div           clocks per fade tick minus 1 (0 = direct follow)
//   step               level change per tick (0 behaves as 1)
//   level              live levels, channel k at [8k+7:8k]
//   busy               any level differs from its target
//   done               one-cycle pulse on the clock busy falls
module led_fade_engine #(
  parameter  int unsigned NCH   = 8,
  parameter  int unsigned DIV_W = 16,
  localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_wen,
  input  logic [CH_W-1:0]  tgt_ch,
  input  logic [7:0]       tgt_val,
  input  logic [DIV_W-1:0] rate_div,
  input  logic [3:0]       step,
  output logic [NCH*8-1:0] level,
  output logic             busy,
  output logic             done
);

  localparam int unsigned     LW       = 8;
  localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NCH - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state_q, state_d;
  logic [CH_W-1:0] idx_q, idx_d;
  logic            pend_q, pend_d;
  logic [DIV_W-1:0] cnt_q;
  logic [LW-1:0]   level_q  [NCH];
  logic [LW-1:0]   target_q [NCH];
  logic            busy_q, done_q;

  logic            tick_c, bypass_c, upd_c, busy_c, wr_ok_c;
  logic [LW-1:0]   s_c, cur_lvl_c, cur_tgt_c, new_lvl_c;

  assign tick_c   = (cnt_q == '0);
  assign bypass_c = (rate_div == '0);
  assign wr_ok_c  = tgt_wen && (32'(tgt_ch) < NCH);

  // Free-running prescaler; rate_div is picked up at each reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt_q <= '0;
    else if (tick_c) cnt_q <= rate_div;
    else             cnt_q <= cnt_q - DIV_W'(1);
  end

  // Scan state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
    end
  end

  // Scan sequencing: one channel per clock; one tick landing mid-scan is
  // remembered and restarts the scan back-to-back, extra ones are dropped.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    upd_c   = 1'b0;
    if (bypass_c) begin
      state_d = IDLE;
      idx_d   = '0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick_c) begin
            state_d = SCAN;
            idx_d   = '0;
          end
        end
        SCAN: begin
          upd_c = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            pend_d = 1'b0;
            if (!(pend_q || tick_c)) state_d = IDLE;
          end else begin
            idx_d = idx_q + CH_W'(1);
            if (tick_c) pend_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Next level for the channel under scan; clamps to target, never wraps.
  always_comb begin
    s_c       = (step == 4'd0) ? LW'(1) : LW'(step);
    cur_lvl_c = level_q[idx_q];
    cur_tgt_c = target_q[idx_q];
    new_lvl_c = cur_tgt_c;
    if (cur_tgt_c > cur_lvl_c) begin
      if ((cur_tgt_c - cur_lvl_c) > s_c) new_lvl_c = cur_lvl_c + s_c;
    end else if (cur_tgt_c < cur_lvl_c) begin
      if ((cur_lvl_c - cur_tgt_c) > s_c) new_lvl_c = cur_lvl_c - s_c;
    end
  end

  // Level and target storage; the scan reads the pre-write target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        level_q[k]  <= '0;
        target_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (bypass_c)                            level_q[k] <= target_q[k];
        else if (upd_c && (idx_q == CH_W'(k)))   level_q[k] <= new_lvl_c;
      end
      if (wr_ok_c) target_q[tgt_ch] <= tgt_val;
    end
  end

  // Mismatch detect; direct-follow mode never reports busy since the
  // level trails the target by a fixed single clock.
  always_comb begin
    busy_c = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (level_q[k] != target_q[k]) busy_c = 1'b1;
    end
    busy_c = busy_c && !bypass_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_c;
      done_q <= busy_q && !busy_c;
    end
  end

  always_comb begin
    level = '0;
    for (int k = 0; k < NCH; k++) level[k*LW +: LW] = level_q[k];
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule
